// File: rtl/rs_station.sv
// Reservation-station bank: allocates fixed-tag slots on issue, captures operands
// from the CDB, and feeds ready tasks to a functional unit through a dispatch register.
module rs_station #(
    parameter int unsigned NUM_ENT  = 4,
    parameter int unsigned TAG_W    = 4,
    parameter int unsigned BASE_TAG = 1,
    parameter int unsigned OP_W     = 7
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           issue_valid,
    output logic                           issue_ready,
    input  logic [OP_W-1:0]                issue_op,
    input  logic [31:0]                    issue_v1,
    input  logic [31:0]                    issue_v2,
    input  logic [TAG_W-1:0]               issue_t1,
    input  logic [TAG_W-1:0]               issue_t2,
    output logic [TAG_W-1:0]               issue_tag,
    input  logic                           cdb_valid,
    input  logic [TAG_W-1:0]               cdb_tag,
    input  logic [31:0]                    cdb_data,
    output logic                           disp_valid,
    input  logic                           disp_ready,
    output logic [OP_W-1:0]                disp_op,
    output logic [31:0]                    disp_a,
    output logic [31:0]                    disp_b,
    output logic [TAG_W-1:0]               disp_tag,
    output logic [$clog2(NUM_ENT+1)-1:0]   occupancy
);

    localparam int unsigned IDX_W = (NUM_ENT > 1) ? $clog2(NUM_ENT) : 1;
    localparam int unsigned OCC_W = $clog2(NUM_ENT + 1);

    logic [NUM_ENT-1:0] busy;
    logic [OP_W-1:0]    op_q [NUM_ENT];
    logic [31:0]        v1_q [NUM_ENT];
    logic [31:0]        v2_q [NUM_ENT];
    logic [TAG_W-1:0]   t1_q [NUM_ENT];
    logic [TAG_W-1:0]   t2_q [NUM_ENT];

    logic               free_found;
    logic [IDX_W-1:0]   free_idx;
    logic               cand_found;
    logic [IDX_W-1:0]   cand_idx;
    logic               do_issue;
    logic               do_load;
    logic               cdb_hit;
    logic [31:0]        new_v1;
    logic [31:0]        new_v2;
    logic [TAG_W-1:0]   new_t1;
    logic [TAG_W-1:0]   new_t2;
    logic [OCC_W-1:0]   occ_sum;

    // Lowest free slot and lowest ready slot, both from registered state
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        cand_found = 1'b0;
        cand_idx   = '0;
        for (int i = NUM_ENT - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (busy[i] && (t1_q[i] == '0) && (t2_q[i] == '0)) begin
                cand_found = 1'b1;
                cand_idx   = IDX_W'(i);
            end
        end
    end

    assign issue_ready = free_found;
    assign issue_tag   = free_found ? (TAG_W'(BASE_TAG) + TAG_W'(free_idx)) : '0;
    assign do_issue    = issue_valid && free_found;
    assign do_load     = cand_found && (!disp_valid || disp_ready);
    assign cdb_hit     = cdb_valid && (cdb_tag != '0);

    // A broadcast seen in the allocating cycle is folded into the new slot directly
    always_comb begin
        new_v1 = issue_v1;
        new_t1 = issue_t1;
        new_v2 = issue_v2;
        new_t2 = issue_t2;
        if (cdb_hit && (issue_t1 == cdb_tag)) begin
            new_v1 = cdb_data;
            new_t1 = '0;
        end
        if (cdb_hit && (issue_t2 == cdb_tag)) begin
            new_v2 = cdb_data;
            new_t2 = '0;
        end
    end

    always_comb begin
        occ_sum = '0;
        for (int i = 0; i < NUM_ENT; i++) begin
            occ_sum = occ_sum + OCC_W'(busy[i]);
        end
    end

    assign occupancy = occ_sum;

    // Slot array: free on dispatch load, capture from CDB, write on allocation
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            busy <= '0;
            for (int i = 0; i < NUM_ENT; i++) begin
                op_q[i] <= '0;
                v1_q[i] <= '0;
                v2_q[i] <= '0;
                t1_q[i] <= '0;
                t2_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ENT; i++) begin
                if (do_load && (cand_idx == IDX_W'(i))) begin
                    busy[i] <= 1'b0;
                end
                if (busy[i] && cdb_hit && (t1_q[i] == cdb_tag)) begin
                    v1_q[i] <= cdb_data;
                    t1_q[i] <= '0;
                end
                if (busy[i] && cdb_hit && (t2_q[i] == cdb_tag)) begin
                    v2_q[i] <= cdb_data;
                    t2_q[i] <= '0;
                end
                if (do_issue && (free_idx == IDX_W'(i))) begin
                    busy[i] <= 1'b1;
                    op_q[i] <= issue_op;
                    v1_q[i] <= new_v1;
                    v2_q[i] <= new_v2;
                    t1_q[i] <= new_t1;
                    t2_q[i] <= new_t2;
                end
            end
        end
    end

    // Dispatch register: holds stable while the FU stalls
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            disp_valid <= 1'b0;
            disp_op    <= '0;
            disp_a     <= '0;
            disp_b     <= '0;
            disp_tag   <= '0;
        end else if (do_load) begin
            disp_valid <= 1'b1;
            disp_op    <= op_q[cand_idx];
            disp_a     <= v1_q[cand_idx];
            disp_b     <= v2_q[cand_idx];
            disp_tag   <= TAG_W'(BASE_TAG) + TAG_W'(cand_idx);
        end else if (disp_valid && disp_ready) begin
            disp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rs_station.sv
// Directed self-checking bench for rs_station: issue, CDB capture, bypass,
// full-bank handling, dispatch stall and asynchronous reset.
module tb_rs_station;

    logic        CLK;
    logic        RST;
    logic        issue_valid;
    logic        issue_ready;
    logic [6:0]  issue_op;
    logic [31:0] issue_v1;
    logic [31:0] issue_v2;
    logic [3:0]  issue_t1;
    logic [3:0]  issue_t2;
    logic [3:0]  issue_tag;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        disp_valid;
    logic        disp_ready;
    logic [6:0]  disp_op;
    logic [31:0] disp_a;
    logic [31:0] disp_b;
    logic [3:0]  disp_tag;
    logic [2:0]  occupancy;

    int checks = 0;
    int errors = 0;

    rs_station #(.NUM_ENT(4), .TAG_W(4), .BASE_TAG(1), .OP_W(7)) dut (
        .CLK(CLK), .RST(RST),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
        .issue_v1(issue_v1), .issue_v2(issue_v2), .issue_t1(issue_t1), .issue_t2(issue_t2),
        .issue_tag(issue_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
        .disp_a(disp_a), .disp_b(disp_b), .disp_tag(disp_tag),
        .occupancy(occupancy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_issue(input logic [6:0] op, input logic [31:0] v1, input logic [3:0] t1,
                               input logic [31:0] v2, input logic [3:0] t2);
        issue_valid = 1'b1;
        issue_op    = op;
        issue_v1    = v1;
        issue_t1    = t1;
        issue_v2    = v2;
        issue_t2    = t2;
    endtask

    initial begin
        RST = 1'b1;
        issue_valid = 1'b0; issue_op = '0; issue_v1 = '0; issue_v2 = '0;
        issue_t1 = '0; issue_t2 = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
        disp_ready = 1'b0;
        #3;
        check("rst_disp_valid", disp_valid, 0);
        check("rst_issue_ready", issue_ready, 1);
        check("rst_issue_tag", issue_tag, 1);
        check("rst_occupancy", occupancy, 0);
        check("rst_disp_tag", disp_tag, 0);
        #9 RST = 1'b0;

        // Ready-on-issue task dispatches one edge after allocation
        drive_issue(7'h33, 32'd5, 4'd0, 32'd7, 4'd0);
        check("t1_issue_tag", issue_tag, 1);
        tick();
        issue_valid = 1'b0;
        check("t1_occ_after_issue", occupancy, 1);
        check("t1_not_yet_disp", disp_valid, 0);
        disp_ready = 1'b1;
        tick();
        check("t1_disp_valid", disp_valid, 1);
        check("t1_disp_a", disp_a, 5);
        check("t1_disp_b", disp_b, 7);
        check("t1_disp_tag", disp_tag, 1);
        check("t1_disp_op", disp_op, 32'h33);
        check("t1_occ_zero", occupancy, 0);
        tick();
        check("t1_disp_drop", disp_valid, 0);

        // Operand captured from a later CDB broadcast
        drive_issue(7'h01, 32'hDEAD, 4'd2, 32'd9, 4'd0);
        check("t2_issue_tag", issue_tag, 1);
        tick();
        issue_valid = 1'b0;
        tick();
        check("t2_waiting", disp_valid, 0);
        cdb_valid = 1'b1; cdb_tag = 4'd2; cdb_data = 32'h100;
        tick();
        cdb_valid = 1'b0;
        check("t2_capture_no_disp", disp_valid, 0);
        check("t2_occ", occupancy, 1);
        tick();
        check("t2_disp_valid", disp_valid, 1);
        check("t2_disp_a", disp_a, 32'h100);
        check("t2_disp_b", disp_b, 9);
        check("t2_disp_tag", disp_tag, 1);
        tick();
        check("t2_disp_drop", disp_valid, 0);
        check("t2_occ_zero", occupancy, 0);

        // Bypass: broadcast coincides with allocation
        drive_issue(7'h02, 32'h11, 4'd0, 32'hBAD, 4'd3);
        cdb_valid = 1'b1; cdb_tag = 4'd3; cdb_data = 32'hABCD;
        tick();
        issue_valid = 1'b0;
        cdb_valid = 1'b0;
        check("t3_occ", occupancy, 1);
        tick();
        check("t3_disp_valid", disp_valid, 1);
        check("t3_disp_a", disp_a, 32'h11);
        check("t3_disp_b", disp_b, 32'hABCD);
        tick();
        check("t3_disp_drop", disp_valid, 0);

        // Fill the bank with tasks pending on tag 9
        disp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_issue(7'(i), 32'd0, 4'd9, 32'h20 + 32'(i), 4'd0);
            check("t4_issue_tag", issue_tag, 32'(i + 1));
            tick();
        end
        check("t4_full_occ", occupancy, 4);
        check("t4_full_ready", issue_ready, 0);
        check("t4_full_tag", issue_tag, 0);
        drive_issue(7'h7F, 32'hFFFF, 4'd0, 32'hFFFF, 4'd0);
        tick();
        issue_valid = 1'b0;
        check("t4_ignored_occ", occupancy, 4);
        check("t4_ignored_tag", issue_tag, 0);
        cdb_valid = 1'b1; cdb_tag = 4'd9; cdb_data = 32'h900;
        tick();
        cdb_valid = 1'b0;
        check("t4_capture_no_disp", disp_valid, 0);
        check("t4_capture_occ", occupancy, 4);
        tick();
        check("t5_disp_valid", disp_valid, 1);
        check("t5_disp_tag", disp_tag, 1);
        check("t5_disp_a", disp_a, 32'h900);
        check("t5_disp_b", disp_b, 32'h20);
        check("t5_occ3", occupancy, 3);
        check("t5_issue_tag", issue_tag, 1);
        disp_ready = 1'b1;
        tick();
        disp_ready = 1'b0;
        check("t5_next_tag", disp_tag, 2);
        check("t5_next_b", disp_b, 32'h21);
        check("t5_occ2", occupancy, 2);
        check("t5_issue_tag2", issue_tag, 1);

        // Stall: a lower slot becomes ready but the dispatch register must hold
        drive_issue(7'h55, 32'h77, 4'd0, 32'h78, 4'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            issue_valid = 1'b0;
            check("t6_hold_valid", disp_valid, 1);
            check("t6_hold_tag", disp_tag, 2);
            check("t6_hold_a", disp_a, 32'h900);
            check("t6_hold_b", disp_b, 32'h21);
        end
        check("t6_occ", occupancy, 3);

        // Asynchronous reset mid-stall, away from any clock edge
        @(posedge CLK);
        #2 RST = 1'b1;
        #1;
        check("t6_rst_disp_valid", disp_valid, 0);
        check("t6_rst_issue_tag", issue_tag, 1);
        check("t6_rst_occ", occupancy, 0);
        check("t6_rst_issue_ready", issue_ready, 1);
        check("t6_rst_disp_tag", disp_tag, 0);
        #4 RST = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rs_station.md
Name: rs_station

Overview:
- Reservation-station bank sitting directly downstream of the register map table in the out-of-order OTTER issue path.
- Each slot owns one fixed RS tag. The bank advertises the tag of its next free slot as issue_tag; the map table uses this to rename rd.
- Accepted tasks wait in a slot until both source operands are available, either from issue or captured from the CDB.
- Ready tasks move through a registered dispatch stage to the functional unit under a valid/ready handshake.

Parameters:
- NUM_ENT, 4, number of slots (2..8).
- TAG_W, 4, RS tag width; tag value 0 is INVALID, meaning "no pending producer".
- BASE_TAG, 1, tag of slot 0; slot i owns tag BASE_TAG+i; BASE_TAG+NUM_ENT-1 < 2^TAG_W.
- OP_W, 7, width of the opaque operation field carried to the FU.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- issue_valid  in  1  task presented for allocation.
- issue_ready  out  1  at least one free slot.
- issue_op  in  OP_W  operation field.
- issue_v1, issue_v2  in  32  operand values (meaningful only when the matching tag is 0).
- issue_t1, issue_t2  in  TAG_W  pending-producer tags from the map table; 0 = value is valid.
- issue_tag  out  TAG_W  tag of the slot the next accepted issue will occupy; 0 when full.
- cdb_valid  in  1  CDB broadcast present.
- cdb_tag  in  TAG_W  broadcast tag.
- cdb_data  in  32  broadcast value.
- disp_valid  out  1  dispatch register holds a task.
- disp_ready  in  1  FU accepts the task.
- disp_op  out  OP_W  dispatched operation.
- disp_a, disp_b  out  32  dispatched operands.
- disp_tag  out  TAG_W  tag of the dispatched task; the FU returns this tag on the CDB.
- occupancy  out  $clog2(NUM_ENT+1)  busy slots, excluding the dispatch register.

Behaviour:
- Reset, asynchronous, takes effect immediately:
  - all slots free; dispatch register empty.
  - disp_valid=0, disp_op/disp_a/disp_b/disp_tag=0, occupancy=0.
  - issue_ready=1, issue_tag=BASE_TAG.
  - Reset mid-operation discards all slots and any in-flight dispatch without a handshake.
- Slot state: busy, op, v1, v2, t1, t2. An operand is ready when its tag is 0.
- Allocation:
  - issue_tag = BASE_TAG + (lowest-index free slot), computed from registered busy bits.
  - On a rising edge with issue_valid && issue_ready, that slot is written and marked busy.
  - issue_valid while full is ignored; no state changes.
  - A slot freed this cycle is not reusable until the next cycle.
- CDB capture:
  - On each edge with cdb_valid && cdb_tag!=0, every busy slot with t1==cdb_tag loads v1=cdb_data and sets t1=0; t2/v2 likewise.
  - Multiple slots may capture the same broadcast.
- Issue/CDB bypass: if issue_t1 (or issue_t2) equals cdb_tag while cdb_valid is high in the allocating cycle, the new slot stores cdb_data with tag 0. It must not wait for a broadcast that has already passed.
- Selection:
  - Candidate = lowest-index busy slot with t1==0 && t2==0, evaluated on registered state.
  - A slot made ready by a CDB capture or by issue at edge N becomes a candidate after edge N; it enters the dispatch register no earlier than edge N+1.
- Dispatch register:
  - Loads a candidate on an edge when it is empty, or when disp_valid && disp_ready that cycle.
  - The candidate slot is freed on the same edge it is loaded.
  - Throughput: one task per cycle under continuous disp_ready.
  - While disp_valid && !disp_ready, all disp_* outputs hold stable; no new load.
  - After an accept with no candidate, disp_valid falls to 0.
- Dispatch register contents do not snoop the CDB; they are always fully ready.
- Simultaneous issue, CDB capture, and dispatch-load in one cycle are all legal and independent, except for the bypass rule above.
- occupancy equals the popcount of the busy bits and updates on the same edge.

Test Plan:
- After reset, issue op=0x33, v1=5, v2=7, t1=t2=0 → issue_tag=1 at issue. One edge later disp_valid=1, disp_a=5, disp_b=7, disp_tag=1. With disp_ready=1 → occupancy returns to 0.
- Issue with t1=2, v2=9. Broadcast cdb_tag=2, data=0x100 two cycles later → disp_valid rises one edge after the capture, disp_a=0x100, disp_b=9.
- Issue with t2=3 in the same cycle as cdb_valid, cdb_tag=3, data=0xABCD → no wait; dispatched next edge with disp_b=0xABCD.
- With disp_ready=0, issue 4 tasks → tags 1,2,3,4; then issue_ready=0, issue_tag=0, and a 5th issue_valid is ignored.
- Pull disp_ready=1 one cycle → slot 1 frees; issue_tag=1 one edge later; occupancy falls 4→3→2.
- Hold disp_ready=0 for 5 cycles with a lower slot becoming ready → disp_tag and disp_a stay constant. Assert RST mid-hold → disp_valid=0 and issue_tag=1 immediately, without waiting for a clock edge.
